// File: rtl/haze_pkg.sv
// haze_pkg: shared pixel/transmission widths, default frame geometry and sequencer state encoding
package haze_pkg;
  localparam int PIX_W = 24;
  localparam int T_W = 17;
  localparam int IMG_W = 512;
  localparam int IMG_H = 512;
  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;
endpackage

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: col/row tracker; clr restarts, adv steps one pixel, sof/eol/eof flag the current position
module frame_pos_counter #(
  parameter int W = 512,
  parameter int H = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic sof,
  output logic eol,
  output logic eof
);
  localparam int CW = W > 1 ? $clog2(W) : 1;
  localparam int RW = H > 1 ? $clog2(H) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  assign sof = col == '0 && row == '0;
  assign eol = col == CW'(W - 1);
  assign eof = eol && row == RW'(H - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      col <= eol ? '0 : col + CW'(1);
      row <= eol ? (eof ? '0 : row + RW'(1)) : row;
    end
  end
endmodule

// File: rtl/haze_frame_sequencer.sv
// haze_frame_sequencer: feeds one BGR frame (start/s_*) to the engine (eng_*), flushes it, forwards transmissions (m_*), reports frame_done/err_*
module haze_frame_sequencer #(
  parameter int IMG_W = haze_pkg::IMG_W,
  parameter int IMG_H = haze_pkg::IMG_H,
  parameter int FLUSH_BEATS = 2 * haze_pkg::IMG_W + 6,
  parameter int TIMEOUT = 4096,
  parameter int PIX_W = haze_pkg::PIX_W,
  parameter int T_W = haze_pkg::T_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  input  logic [PIX_W-1:0] s_pixel,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] eng_pixel,
  output logic             eng_valid,
  output logic             eng_flush,
  output logic             eng_sof,
  output logic             eng_eol,
  input  logic [T_W-1:0]   eng_trans,
  input  logic             eng_trans_valid,
  output logic [T_W-1:0]   m_trans,
  output logic             m_valid,
  output logic             m_last,
  output logic             frame_done,
  output logic             err_timeout,
  output logic             err_overrun
);
  import haze_pkg::*;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int FL_W = $clog2(FLUSH_BEATS + 1);
  localparam int ID_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TOT = CNT_W'(TOTAL);
  state_t state;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic [FL_W-1:0] flush_cnt;
  logic [ID_W-1:0] idle_cnt, idle_nxt;
  logic hs, clr, act, take, sof, eol, eof;
  assign s_ready = state == RUN && in_cnt < TOT;
  assign hs = s_valid && s_ready;
  assign clr = state == IDLE && start;
  assign busy = state != IDLE;
  assign act = state == RUN || state == FLUSH || state == DRAIN;
  assign take = act && eng_trans_valid && out_cnt < TOT;
  assign idle_nxt = eng_trans_valid ? '0 : idle_cnt + ID_W'(1);
  frame_pos_counter #(.W(IMG_W), .H(IMG_H)) u_pos (
    .clk(clk), .rst(rst), .clr(clr), .adv(hs), .sof(sof), .eol(eol), .eof(eof)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {in_cnt, out_cnt, flush_cnt, idle_cnt} <= '0;
      {eng_valid, eng_flush, eng_sof, eng_eol, m_valid, m_last, frame_done, err_timeout, err_overrun} <= '0;
      eng_pixel <= '0;
      m_trans <= '0;
    end else begin
      eng_valid <= hs || state == FLUSH;
      eng_flush <= state == FLUSH;
      eng_pixel <= hs ? s_pixel : '0;
      eng_sof <= hs && sof;
      eng_eol <= hs && eol;
      m_valid <= take;
      m_last <= take && out_cnt == TOT - CNT_W'(1);
      frame_done <= 1'b0;
      if (take) begin
        m_trans <= eng_trans;
        out_cnt <= out_cnt + CNT_W'(1);
      end
      if (act && eng_trans_valid && out_cnt == TOT) err_overrun <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          {in_cnt, out_cnt, flush_cnt, idle_cnt} <= '0;
          {err_timeout, err_overrun} <= '0;
        end
        RUN: if (hs) begin
          in_cnt <= in_cnt + CNT_W'(1);
          if (eof) state <= FLUSH;
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + FL_W'(1);
          if (flush_cnt == FL_W'(FLUSH_BEATS - 1)) state <= DRAIN;
        end
        DRAIN: begin
          idle_cnt <= idle_nxt;
          // a complete output count wins over a coincident timeout
          if (out_cnt == TOT || idle_nxt == ID_W'(TIMEOUT)) begin
            state <= DONE;
            frame_done <= 1'b1;
            err_timeout <= out_cnt != TOT;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
